// File: rtl/pipelined_carry_skip_adder.sv
// pipelined_carry_skip_adder: WIDTH-bit add/sub built from BLOCK_W-bit carry-skip blocks, one block per stage
`timescale 1ns/1ps
module pipelined_carry_skip_adder #(
    parameter int WIDTH   = 32,
    parameter int BLOCK_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NB = WIDTH / BLOCK_W;
    if (WIDTH % BLOCK_W != 0) begin : g_width_chk
        $error("WIDTH must be a multiple of BLOCK_W");
    end
    logic               r_v  [NB];
    logic [WIDTH-1:0]   r_a  [NB];
    logic [WIDTH-1:0]   r_b  [NB];
    logic [WIDTH-1:0]   r_s  [NB];
    logic               r_c  [NB];
    logic               r_cm [NB];
    logic [WIDTH-1:0]   w_ia [NB];
    logic [WIDTH-1:0]   w_ib [NB];
    logic [WIDTH-1:0]   w_is [NB];
    logic [WIDTH-1:0]   w_ns [NB];
    logic               w_ic [NB];
    logic               w_iv [NB];
    logic [BLOCK_W+1:0] w_blk[NB];
    logic               w_adv;
    // returns {skip-muxed carry out, ripple carry into block MSB, block sum}
    function automatic logic [BLOCK_W+1:0] blk(input logic [BLOCK_W-1:0] x, input logic [BLOCK_W-1:0] y,
                                               input logic c);
        logic [BLOCK_W:0]   cc;
        logic [BLOCK_W-1:0] s;
        cc[0] = c;
        for (int i = 0; i < BLOCK_W; i++) begin
            s[i]     = x[i] ^ y[i] ^ cc[i];
            cc[i+1]  = (x[i] & y[i]) | (cc[i] & (x[i] ^ y[i]));
        end
        return {(&(x ^ y)) ? c : cc[BLOCK_W], cc[BLOCK_W-1], s};
    endfunction
    assign w_adv     = ~r_v[NB-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[NB-1];
    assign sum       = r_s[NB-1];
    assign cout      = r_c[NB-1];
    assign ovf       = r_cm[NB-1] ^ r_c[NB-1];
    always_comb begin
        w_ia[0] = a;
        w_ib[0] = sub ? ~b : b;
        w_ic[0] = sub | cin;
        w_is[0] = '0;
        w_iv[0] = in_valid;
        for (int k = 1; k < NB; k++) begin
            w_ia[k] = r_a[k-1];
            w_ib[k] = r_b[k-1];
            w_ic[k] = r_c[k-1];
            w_is[k] = r_s[k-1];
            w_iv[k] = r_v[k-1];
        end
        for (int k = 0; k < NB; k++) begin
            w_blk[k] = blk(w_ia[k][k*BLOCK_W +: BLOCK_W], w_ib[k][k*BLOCK_W +: BLOCK_W], w_ic[k]);
            w_ns[k]  = w_is[k];
            w_ns[k][k*BLOCK_W +: BLOCK_W] = w_blk[k][BLOCK_W-1:0];
        end
    end
    // global stall: every stage holds when the output is occupied and not taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NB; k++) begin
                r_v[k]  <= 1'b0;
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
                r_c[k]  <= 1'b0;
                r_cm[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NB; k++) begin
                r_v[k]  <= w_iv[k];
                r_a[k]  <= w_ia[k];
                r_b[k]  <= w_ib[k];
                r_s[k]  <= w_ns[k];
                r_c[k]  <= w_blk[k][BLOCK_W+1];
                r_cm[k] <= w_blk[k][BLOCK_W];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// tb_pipelined_carry_skip_adder: directed and streamed checks of the 32-bit, 4-stage adder/subtractor
`timescale 1ns/1ps
module tb_pipelined_carry_skip_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [33:0] nxt_exp = '0;
    logic [33:0] exp_q[$];
    int          out_cyc[$];

    pipelined_carry_skip_adder #(.WIDTH(32), .BLOCK_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference: plain 33-bit add, carry into MSB from the low 31 bits
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                          input logic c);
        logic [31:0] yy = s ? ~y : y;
        logic        c0 = s | c;
        logic [32:0] t  = {1'b0, x} + {1'b0, yy} + 33'(c0);
        logic [31:0] lo = {1'b0, x[30:0]} + {1'b0, yy[30:0]} + 32'(c0);
        return {t[32], t[32] ^ lo[31], t[31:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", 34'(out_valid), 34'(0));
                else begin
                    chk("result", {cout, ovf, sum}, exp_q.pop_front());
                    out_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(nxt_exp);
        end
    end

    // call just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c,
                        input logic [33:0] e);
        int n = 0;
        a = x; b = y; sub = s; cin = c; nxt_exp = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 34'(in_ready), 34'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        chk("drain", 34'(exp_q.size()), 34'(0));
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic held;
        logic [33:0] hs;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {cout, ovf, sum}, 34'(0));
        chk("rst_valid", 34'(out_valid), 34'(0));
        chk("rst_in_ready", 34'(in_ready), 34'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h1, 32'h2, 1'b0, 1'b0, {2'b00, 32'h3});
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("lat_early", 34'(n), 34'(0));
        @(negedge clk);
        chk("lat_valid", 34'(out_valid), 34'(1));
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, {2'b10, 32'h0});
        send(32'h8000_0000, 32'h1, 1'b1, 1'b0, {2'b11, 32'h7FFF_FFFF});
        send(32'h5, 32'h7, 1'b1, 1'b0, {2'b00, 32'hFFFF_FFFE});
        send(32'h5, 32'h7, 1'b1, 1'b1, {2'b00, 32'hFFFF_FFFE});
        send(32'h1234_5678, 32'h0, 1'b1, 1'b0, {2'b10, 32'h1234_5678});
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {2'b01, 32'h8000_0000});
        send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, {2'b00, 32'h0100_0100});
        drain();
        base = out_cyc.size();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] x = $urandom;
            logic [31:0] y = $urandom;
            logic        s = 1'($urandom_range(0, 1));
            logic        c = 1'($urandom_range(0, 1));
            send(x, y, s, c, model(x, y, s, c));
        end
        drain();
        chk("stream_cnt", 34'(out_cyc.size() - base), 34'(8));
        if (out_cyc.size() >= base + 8) chk("stream_gap", 34'(out_cyc[base+7] - out_cyc[base]), 34'(7));
        out_ready = 1'b0;
        held = 1'b0;
        hs = '0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [31:0] x = $urandom;
                    logic [31:0] y = $urandom;
                    logic        s = 1'(i & 1);
                    send(x, y, s, 1'b1, model(x, y, s, 1'b1));
                end
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!held) begin
                            hs = {cout, ovf, sum};
                            held = 1'b1;
                        end else chk("bp_hold", {cout, ovf, sum}, hs);
                        chk("bp_in_ready", 34'(in_ready), 34'(0));
                    end
                end
                chk("bp_seen", 34'(held), 34'(1));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 4; i++) send(32'(i * 3 + 1), 32'(i), 1'b0, 1'b0, model(32'(i * 3 + 1), 32'(i), 1'b0, 1'b0));
        chk("pre_rst_valid", 34'(out_valid), 34'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 34'(out_valid), 34'(0));
        chk("rst_mid_out", {cout, ovf, sum}, 34'(0));
        chk("rst_mid_in_ready", 34'(in_ready), 34'(1));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("post_rst_quiet", 34'(n), 34'(0));
        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, {2'b10, 32'h0000_0000});
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
